// File: rtl/serial_subtractor_ctrl_if.sv
// Host-side handshake and operand bus for serial_subtractor_ctrl.
// Optional macro: SUB_BORROW_IN_EN adds the Bin initial-borrow signal.
interface serial_subtractor_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SUB_BORROW_IN_EN
    logic             Bin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

`ifdef SUB_BORROW_IN_EN
    modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout);
`else
    modport master (output start, A, B, input busy, done, Diff, Bout);
    modport slave  (input start, A, B, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction controller: one shared full-subtractor cell plus a
// borrow flop, stepped LSB first across WIDTH-bit operands.
// Optional macro: SUB_BORROW_IN_EN captures bus.Bin as the initial borrow;
// without it the initial borrow is constant 0.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_diff;
    logic             cell_bout;
    logic             bin_init;

`ifdef SUB_BORROW_IN_EN
    assign bin_init = bus.Bin;
`else
    assign bin_init = 1'b0;
`endif

    // Shared full-subtractor cell and the result register's next value.
    always_comb begin
        cell_diff        = a_q[0] ^ b_q[0] ^ borrow_q;
        cell_bout        = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = cell_diff;
    end

    // Sequencing FSM with registered busy/done and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        borrow_q <= bin_init;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    res_q    <= res_d;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= cell_bout;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LastCnt) begin
                        // Publish the completed result; it holds until the next completion.
                        diff_q  <= res_d;
                        bout_q  <= cell_bout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: a WIDTH=8 instance for the
// directed cases and a WIDTH=4 instance for the exhaustive sweep.
module tb_serial_subtractor_ctrl;
    logic clk;
    logic rst;
    logic bin8;
    logic bin4;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor_ctrl_if #(.WIDTH(8)) b8 ();
    serial_subtractor_ctrl_if #(.WIDTH(4)) b4 ();

`ifdef SUB_BORROW_IN_EN
    assign b8.Bin = bin8;
    assign b4.Bin = bin4;
`endif

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: edges elapsed since acceptance, plus the arithmetic result.
    int     wd[2] = '{8, 4};
    int     since[2] = '{-1, -1};
    longint pend_diff[2];
    longint pend_bout[2];
    longint m_diff[2] = '{0, 0};
    longint m_bout[2] = '{0, 0};

    task automatic model_step(input int i, input logic st, input longint a, input longint b,
                              input longint bin);
        longint mask;
        mask = (longint'(1) << wd[i]) - 1;
        if (since[i] < 0) begin
            if (st) begin
                since[i]     = 0;
                pend_diff[i] = (a - b - bin) & mask;
                pend_bout[i] = (a < b + bin) ? 1 : 0;
            end
        end else begin
            since[i]++;
            if (since[i] == wd[i]) begin
                m_diff[i] = pend_diff[i];
                m_bout[i] = pend_bout[i];
            end else if (since[i] == wd[i] + 1) begin
                since[i] = -1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                since[i]  = -1;
                m_diff[i] = 0;
                m_bout[i] = 0;
            end
        end else begin
            model_step(0, b8.start, longint'(b8.A), longint'(b8.B), longint'(bin8));
            model_step(1, b4.start, longint'(b4.A), longint'(b4.B), longint'(bin4));
        end
    end

    task automatic compare(input int i, input logic busy, input logic done, input longint diff,
                           input logic bout);
        logic eb;
        logic ed;
        eb = (since[i] >= 0) && (since[i] < wd[i]);
        ed = (since[i] == wd[i]);
        check($sformatf("w%0d busy", wd[i]), longint'(busy), longint'(eb));
        check($sformatf("w%0d done", wd[i]), longint'(done), longint'(ed));
        check($sformatf("w%0d Diff", wd[i]), diff, m_diff[i]);
        check($sformatf("w%0d Bout", wd[i]), longint'(bout), m_bout[i]);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        compare(0, b8.busy, b8.done, longint'(b8.Diff), b8.Bout);
        compare(1, b4.busy, b4.done, longint'(b4.Diff), b4.Bout);
    end

    // Call just before the accepting edge; drops start after it and waits for done.
    task automatic wait_done8(input string tag, input longint ed, input longint eb,
                              output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            edges++;
            if (edges == 1) b8.start = 1'b0;
            if (b8.busy) busy_cnt++;
        end while (!b8.done && edges < 40);
        check({tag, " done seen"}, longint'(b8.done), 1);
        check({tag, " Diff"}, longint'(b8.Diff), ed);
        check({tag, " Bout"}, longint'(b8.Bout), eb);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input longint ed, input longint eb,
                        output int edges, output int busy_cnt);
        @(negedge clk);
        b8.A     = a;
        b8.B     = b;
        bin8     = bin;
        b8.start = 1'b1;
        wait_done8(tag, ed, eb, edges, busy_cnt);
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int n;
        @(negedge clk);
        b4.A     = a;
        b4.B     = b;
        bin4     = bin;
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        n = 1;
        while (!b4.done && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("w4 sweep done seen", longint'(b4.done), 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int busy_cnt;
        int rises[$];
        logic prev;
        int nbin;

        rst      = 1'b1;
        b8.start = 1'b0;
        b8.A     = '0;
        b8.B     = '0;
        b4.start = 1'b0;
        b4.A     = '0;
        b4.B     = '0;
        bin8     = 1'b0;
        bin4     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", longint'(b8.busy), 0);
        check("reset done", longint'(b8.done), 0);
        check("reset Diff", longint'(b8.Diff), 0);
        check("reset Bout", longint'(b8.Bout), 0);
        rst = 1'b0;
        @(negedge clk);

        run8("5A-23", 8'h5A, 8'h23, 1'b0, 'h37, 0, edges, busy_cnt);
        check("latency edges", edges, 9);
        check("busy cycles", busy_cnt, 8);
        run8("00-01", 8'h00, 8'h01, 1'b0, 'hFF, 1, edges, busy_cnt);
        run8("FF-FF", 8'hFF, 8'hFF, 1'b0, 'h00, 0, edges, busy_cnt);

        // Start held high: accepts every WIDTH+2 cycles, prior result holds while busy.
        @(negedge clk);
        b8.A     = 8'h5A;
        b8.B     = 8'h23;
        b8.start = 1'b1;
        prev     = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (b8.busy && !prev) rises.push_back(k);
            prev = b8.busy;
            if (k == 1) begin
                b8.A = 8'h00;
                b8.B = 8'h01;
            end
            if (k == 15) check("held: Diff holds prior", longint'(b8.Diff), 'h37);
            if (k == 19) check("held: 2nd Diff", longint'(b8.Diff), 'hFF);
            if (k == 30) b8.start = 1'b0;
        end
        check("held: accept count", rises.size(), 3);
        if (rises.size() == 3) begin
            check("held: gap 1", rises[1] - rises[0], 10);
            check("held: gap 2", rises[2] - rises[1], 10);
        end
        repeat (3) @(negedge clk);

        // Asynchronous abort in the 4th SHIFT cycle, start held across release.
        @(negedge clk);
        b8.A     = 8'h5A;
        b8.B     = 8'h23;
        b8.start = 1'b1;
        repeat (4) @(negedge clk);
        b8.start = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("abort busy", longint'(b8.busy), 0);
        check("abort done", longint'(b8.done), 0);
        check("abort Diff", longint'(b8.Diff), 0);
        check("abort Bout", longint'(b8.Bout), 0);
        b8.A     = 8'h80;
        b8.B     = 8'h01;
        b8.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_done8("80-01 after reset", 'h7F, 0, edges, busy_cnt);
        check("post-reset latency", edges, 9);
        @(negedge clk);

`ifdef SUB_BORROW_IN_EN
        run8("10-01-1", 8'h10, 8'h01, 1'b1, 'h0E, 0, edges, busy_cnt);
        run8("00-00-1", 8'h00, 8'h00, 1'b1, 'hFF, 1, edges, busy_cnt);
        nbin = 2;
`else
        nbin = 1;
`endif

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < nbin; c++)
                    run4(4'(a), 4'(b), 1'(c));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
